// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer engine.
//   - spi_state_t     : transfer FSM states (IDLE, LEAD, XFER, TRAIL)
//   - SPPR/SPR fields : positions of the baud-rate fields inside SPIBR
//   - HALF_W          : width of the half-period counter (H ranges 1..1024)
//   - spi_half_period : decodes SPIBR into H = (SPPR+1) * 2^SPR clk cycles
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    localparam int SPPR_MSB = 6;
    localparam int SPPR_LSB = 4;
    localparam int SPR_MSB  = 2;
    localparam int SPR_LSB  = 0;

    localparam int HALF_W = 11;

    // Bits 7 and 3 of SPIBR are reserved and do not affect the result.
    function automatic logic [HALF_W-1:0] spi_half_period(input logic [7:0] spibr);
        logic [HALF_W-1:0] sppr_p1;
        sppr_p1 = HALF_W'(spibr[SPPR_MSB:SPPR_LSB]) + HALF_W'(1);
        return sppr_p1 << spibr[SPR_MSB:SPR_LSB];
    endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// Half-period timer for SCK generation.
// Ports:
//   clk, rst : clock and synchronous active-low reset
//   load     : capture a new half period (H) and restart the count
//   half     : half period in clk cycles, 1..1024
//   en       : count enable (asserted while a transfer is in progress)
//   tick     : one-cycle pulse every H enabled cycles, first one H cycles after load
module spi_sck_divider
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HALF_W-1:0] half,
    input  logic              en,
    output logic              tick
);

    logic [HALF_W-1:0] reload;
    logic [HALF_W-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reload <= '0;
            count  <= '0;
        end else if (load) begin
            // Counting H-1 down to 0 spans exactly H cycles.
            reload <= half - HALF_W'(1);
            count  <= half - HALF_W'(1);
        end else if (en) begin
            if (count == '0) begin
                count <= reload;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign tick = en && (count == '0);

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master transfer engine: one framed, full-duplex DATA_W-bit transfer
// per accepted start request.
// Ports:
//   clk, rst       : clock and synchronous active-low reset
//   spibr          : baud-rate register (SPPR in 6:4, SPR in 2:0)
//   cpol/cpha      : SCK idle level / clock phase
//   lsbfe          : 1 = LSB first, 0 = MSB first
//   start, tx_data : transfer request and word to send (latched on accept)
//   miso           : serial input
//   busy, done     : transfer in progress / one-cycle completion pulse
//   rx_data        : last received word, updated with done
//   sck, mosi, ss_n: SPI bus outputs
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        spibr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    output logic              ss_n
);

    localparam int ECW = $clog2(2 * DATA_W + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_W);
    localparam logic [ECW-1:0] FIRST_EDGE = ECW'(1);

    spi_state_t        state;
    logic              cpha_q;
    logic              lsbfe_q;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [ECW-1:0]    edge_cnt;
    logic              sample_pend;

    logic              accept;
    logic              tick;
    logic              div_en;
    logic [HALF_W-1:0] half_period;
    logic [ECW-1:0]    edge_k;
    logic              odd_edge;
    logic              do_sample;
    logic              do_shift;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_merged;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic b, input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    assign accept      = (state == IDLE) && start;
    assign div_en      = (state != IDLE);
    assign half_period = spi_half_period(spibr);

    // Number of the SCK edge produced on the current tick.
    assign edge_k   = edge_cnt + 1'b1;
    assign odd_edge = edge_k[0];

    // CPHA=0: sample on odd edges, advance on even edges except the last.
    // CPHA=1: advance on odd edges (edge 1 re-drives the first bit), sample on even edges.
    assign do_sample = cpha_q ? !odd_edge : odd_edge;
    assign do_shift  = cpha_q ? (odd_edge && (edge_k != FIRST_EDGE))
                              : (!odd_edge && (edge_k != LAST_EDGE));
    assign tx_next   = lsbfe_q ? (tx_shift >> 1) : (tx_shift << 1);

    // miso is captured in the cycle the sampling edge is visible on sck, which
    // is one cycle after the tick that made it. With H=1 that capture lands on
    // the completion edge, so the finished word folds in the pending bit here.
    assign rx_merged = sample_pend ? shift_in(rx_shift, miso, lsbfe_q) : rx_shift;

    spi_sck_divider u_div (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .half (half_period),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rx_data     <= '0;
            sck         <= 1'b0;
            mosi        <= 1'b0;
            ss_n        <= 1'b1;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            edge_cnt    <= '0;
            sample_pend <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only pulse for one
            // cycle; later assignments in this block override the default.
            done <= 1'b0;

            if (sample_pend) begin
                rx_shift    <= shift_in(rx_shift, miso, lsbfe_q);
                sample_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    sck <= cpol;
                    if (start) begin
                        state    <= LEAD;
                        busy     <= 1'b1;
                        ss_n     <= 1'b0;
                        cpha_q   <= cpha;
                        lsbfe_q  <= lsbfe;
                        tx_shift <= tx_data;
                        mosi     <= first_bit(tx_data, lsbfe);
                        rx_shift <= '0;
                        edge_cnt <= '0;
                    end
                end
                LEAD, XFER: begin
                    if (tick) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_k;
                        if (do_sample) begin
                            sample_pend <= 1'b1;
                        end
                        if (do_shift) begin
                            tx_shift <= tx_next;
                            mosi     <= first_bit(tx_next, lsbfe_q);
                        end
                        state <= (edge_k == LAST_EDGE) ? TRAIL : XFER;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ss_n    <= 1'b1;
                        done    <= 1'b1;
                        rx_data <= rx_merged;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter (DATA_W = 8).
// The expected bus waveform is computed per cycle from the transfer timing
// rules (edge count = (t-1)/H, bit index from edge count); a behavioural SPI
// slave supplies miso when loopback is off.
`timescale 1ns/1ps
module tb_spi_master_shifter;

    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   spibr = 8'h00;
    logic         cpol = 1'b0;
    logic         cpha = 1'b0;
    logic         lsbfe = 1'b0;
    logic         start = 1'b0;
    logic [D-1:0] tx_data = '0;
    logic         miso;
    logic         busy;
    logic         done;
    logic [D-1:0] rx_data;
    logic         sck;
    logic         mosi;
    logic         ss_n;

    logic         loopback = 1'b0;
    logic         slave_miso = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_miso;

    spi_master_shifter #(.DATA_W(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .spibr   (spibr),
        .cpol    (cpol),
        .cpha    (cpha),
        .lsbfe   (lsbfe),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sck     (sck),
        .mosi    (mosi),
        .ss_n    (ss_n)
    );

    function automatic int bit_pos(input int m, input bit lsb);
        return lsb ? m : (D - 1 - m);
    endfunction

    function automatic int half_of(input logic [7:0] br);
        return (int'(br[6:4]) + 1) * (2 ** int'(br[2:0]));
    endfunction

    // ---------------- behavioural slave ----------------
    logic [D-1:0] s_word = '0;
    bit           s_lsb = 1'b0;
    bit           s_pha = 1'b0;
    int           s_edges = 0;
    int           s_bit = 0;
    logic         s_prev_ss = 1'b1;
    logic         s_prev_sck = 1'b0;

    always @(negedge clk) begin
        if (ss_n !== 1'b0) begin
            s_prev_ss = 1'b1;
        end else begin
            if (s_prev_ss) begin
                s_edges = 0;
                s_bit   = 0;
            end else if (sck !== s_prev_sck) begin
                s_edges++;
                if (s_pha ? ((s_edges % 2 == 1) && (s_edges > 1))
                          : ((s_edges % 2 == 0) && (s_edges < 2 * D)))
                    s_bit++;
            end
            if (s_bit > D - 1) s_bit = D - 1;
            slave_miso = s_word[bit_pos(s_bit, s_lsb)];
            s_prev_ss  = 1'b0;
        end
        s_prev_sck = sck;
    end

    // ---------------- transfer driver + per-cycle reference ----------------
    int           obs_done_t;
    int           obs_edges;
    int           obs_wave_err;
    int           obs_first_bad;
    int           obs_done_cnt;
    logic [D-1:0] obs_rx;

    // Called at a negedge. Returns at the negedge of the expected done cycle.
    task automatic do_xfer(input logic [7:0] br, input bit pol, input bit pha, input bit lsb,
                           input logic [D-1:0] tx, input logic [D-1:0] sw,
                           input bit lb, input bit hold, input bit disturb);
        int   h, t_done, n, m;
        logic e_sck, e_mosi, e_ss, e_busy, e_done, prev_sck;
        h      = half_of(br);
        t_done = 1 + (2 * D + 1) * h;
        spibr = br; cpol = pol; cpha = pha; lsbfe = lsb; tx_data = tx;
        loopback = lb; s_word = sw; s_lsb = lsb; s_pha = pha;
        start = 1'b1;
        obs_done_t = -1; obs_edges = 0; obs_wave_err = 0; obs_first_bad = -1;
        obs_done_cnt = 0; obs_rx = '0; prev_sck = pol;
        @(posedge clk);
        #1 start = hold;
        for (int t = 1; t <= t_done; t++) begin
            @(negedge clk);
            n = (t - 1) / h;
            if (n > 2 * D) n = 2 * D;
            m = pha ? ((n == 0) ? 0 : (n - 1) / 2) : n / 2;
            if (m > D - 1) m = D - 1;
            e_sck  = pol ^ (n % 2 == 1);
            e_mosi = tx[bit_pos(m, lsb)];
            e_done = (t == t_done);
            e_ss   = (t == t_done);
            e_busy = (t != t_done);
            if (sck !== e_sck || mosi !== e_mosi || ss_n !== e_ss ||
                busy !== e_busy || done !== e_done) begin
                obs_wave_err++;
                if (obs_first_bad < 0) obs_first_bad = t;
            end
            if (t > 1 && sck !== prev_sck) obs_edges++;
            prev_sck = sck;
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_t < 0) obs_done_t = t;
            end
            if (t == t_done) obs_rx = rx_data;
            if (disturb && t == 3) begin
                start = 1'b1; spibr = 8'h77; cpol = ~pol; cpha = ~pha;
                lsbfe = ~lsb; tx_data = ~tx;
            end
            if (disturb && t == 4) start = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; start = 1'b1; cpol = 1'b1; tx_data = '1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, sck, mosi, ss_n, rx_data} !== {5'b00001, {D{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_values: got busy=%b done=%b sck=%b mosi=%b ss_n=%b rx=%h, want 0 0 0 0 1 00",
                     busy, done, sck, mosi, ss_n, rx_data);
        end
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sck, ss_n, busy, done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL idle_cpol: got sck=%b ss_n=%b busy=%b done=%b, want 1 1 0 0",
                     sck, ss_n, busy, done);
        end
    endtask

    task automatic test_loopback();
        do_xfer(8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done_t != 18) begin
            n_bad++; $display("FAIL loop_done_time: got %0d want 18", obs_done_t);
        end
        n_cmp++;
        if (obs_rx !== 8'hA5) begin
            n_bad++; $display("FAIL loop_rx: got %h want a5", obs_rx);
        end
        n_cmp++;
        if (obs_edges != 16) begin
            n_bad++; $display("FAIL loop_edges: got %0d want 16", obs_edges);
        end
        n_cmp++;
        if (obs_wave_err != 0) begin
            n_bad++; $display("FAIL loop_wave: %0d bad cycles, first at t=%0d, want 0", obs_wave_err, obs_first_bad);
        end
    endtask

    task automatic test_mode3_slave();
        do_xfer(8'h12, 1'b1, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done_t != 137) begin
            n_bad++; $display("FAIL mode3_done_time: got %0d want 137", obs_done_t);
        end
        n_cmp++;
        if (obs_rx !== 8'hC3) begin
            n_bad++; $display("FAIL mode3_rx: got %h want c3", obs_rx);
        end
        n_cmp++;
        if (obs_wave_err != 0 || obs_edges != 16) begin
            n_bad++; $display("FAIL mode3_wave: %0d bad cycles (first t=%0d), %0d edges, want 0 and 16",
                              obs_wave_err, obs_first_bad, obs_edges);
        end
    endtask

    task automatic test_lsb_first();
        do_xfer(8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_rx !== 8'h01) begin
            n_bad++; $display("FAIL lsb_rx: got %h want 01", obs_rx);
        end
        n_cmp++;
        if (obs_wave_err != 0) begin
            n_bad++; $display("FAIL lsb_wave: %0d bad cycles, first at t=%0d, want 0", obs_wave_err, obs_first_bad);
        end
    endtask

    task automatic test_ignore_midxfer();
        logic [D-1:0] tx, sw;
        int extra;
        tx = D'($urandom); sw = D'($urandom);
        do_xfer(8'h01, 1'b0, 1'b0, 1'b0, tx, sw, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_done_t != 35 || obs_done_cnt != 1) begin
            n_bad++; $display("FAIL ignore_done: done at %0d (%0d pulses), want 35 (1 pulse)", obs_done_t, obs_done_cnt);
        end
        n_cmp++;
        if (obs_rx !== sw || obs_wave_err != 0) begin
            n_bad++; $display("FAIL ignore_data: rx=%h bad_cycles=%0d, want rx=%h bad_cycles=0", obs_rx, obs_wave_err, sw);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || ss_n !== 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++; $display("FAIL ignore_queued: %0d active cycles after done, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [D-1:0] tx;
        bit pha, lsb;
        for (int i = 0; i < 3; i++) begin
            tx = D'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
            do_xfer(8'h00, 1'b0, pha, lsb, tx, 8'h00, 1'b1, (i < 2), 1'b0);
            n_cmp++;
            if (obs_done_t != 18 || obs_rx !== tx || obs_wave_err != 0) begin
                n_bad++;
                $display("FAIL b2b_%0d: done_t=%0d rx=%h bad_cycles=%0d, want 18 %h 0",
                         i, obs_done_t, obs_rx, obs_wave_err, tx);
            end
        end
    endtask

    task automatic test_abort();
        int pulses;
        spibr = 8'h01; cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; tx_data = D'($urandom);
        loopback = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // Edge 7 becomes visible at t = 1 + 7*H with H = 2.
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ss_n, sck, busy, done, rx_data} !== {4'b1000, {D{1'b0}}}) begin
            n_bad++;
            $display("FAIL abort_state: got ss_n=%b sck=%b busy=%b done=%b rx=%h, want 1 0 0 0 00",
                     ss_n, sck, busy, done, rx_data);
        end
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || ss_n !== 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || rx_data !== '0) begin
            n_bad++; $display("FAIL abort_quiet: %0d active cycles, rx=%h, want 0 and 00", pulses, rx_data);
        end
        do_xfer(8'h00, 1'b0, 1'b1, 1'b0, 8'h5E, 8'h96, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done_t != 18 || obs_rx !== 8'h96 || obs_wave_err != 0) begin
            n_bad++; $display("FAIL abort_recover: done_t=%0d rx=%h bad_cycles=%0d, want 18 96 0",
                              obs_done_t, obs_rx, obs_wave_err);
        end
    endtask

    task automatic test_random();
        logic [7:0]   br;
        logic [D-1:0] tx, sw;
        bit pol, pha, lsb, lb;
        int h;
        for (int i = 0; i < 8; i++) begin
            br  = {1'($urandom), 3'($urandom_range(0, 2)), 1'($urandom), 3'($urandom_range(0, 2))};
            tx  = D'($urandom); sw = D'($urandom);
            pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom); lb = 1'($urandom);
            h   = half_of(br);
            do_xfer(br, pol, pha, lsb, tx, sw, lb, 1'b0, 1'b0);
            n_cmp++;
            if (obs_done_t != 1 + 17 * h || obs_rx !== (lb ? tx : sw) ||
                obs_wave_err != 0 || obs_edges != 16) begin
                n_bad++;
                $display("FAIL random_%0d br=%h: done_t=%0d rx=%h bad=%0d edges=%0d, want %0d %h 0 16",
                         i, br, obs_done_t, obs_rx, obs_wave_err, obs_edges, 1 + 17 * h, lb ? tx : sw);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_max_half();
        do_xfer(8'h77, 1'b0, 1'b1, 1'b1, 8'hB4, 8'h2D, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done_t != 17409) begin
            n_bad++; $display("FAIL maxh_done_time: got %0d want 17409", obs_done_t);
        end
        n_cmp++;
        if (obs_rx !== 8'h2D || obs_wave_err != 0 || obs_edges != 16) begin
            n_bad++; $display("FAIL maxh_data: rx=%h bad=%0d edges=%0d, want 2d 0 16",
                              obs_rx, obs_wave_err, obs_edges);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_mode3_slave();
        test_lsb_first();
        test_ignore_midxfer();
        test_back_to_back();
        test_abort();
        test_random();
        test_max_half();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
